// File: rtl/ex_mem_if.sv
// Execute-to-memory handshake bundle: upstream valid/ready plus write-back request in,
// head entry plus downstream valid/ready out. The buffer takes the slave modport.
interface ex_mem_if;
  logic        ex_mem_i_valid;
  logic        ex_mem_o_ready;
  logic        ex_mem_i_wreg;
  logic [4:0]  ex_mem_i_waddr;
  logic [31:0] ex_mem_i_wdata;
  logic        ex_mem_i_flush;
  logic        ex_mem_o_valid;
  logic        ex_mem_i_ready;
  logic        ex_mem_o_wreg;
  logic [4:0]  ex_mem_o_waddr;
  logic [31:0] ex_mem_o_wdata;

  modport slave (
    input  ex_mem_i_valid, ex_mem_i_wreg, ex_mem_i_waddr, ex_mem_i_wdata,
    input  ex_mem_i_flush, ex_mem_i_ready,
    output ex_mem_o_ready, ex_mem_o_valid, ex_mem_o_wreg, ex_mem_o_waddr, ex_mem_o_wdata
  );

  modport master (
    output ex_mem_i_valid, ex_mem_i_wreg, ex_mem_i_waddr, ex_mem_i_wdata,
    output ex_mem_i_flush, ex_mem_i_ready,
    input  ex_mem_o_ready, ex_mem_o_valid, ex_mem_o_wreg, ex_mem_o_waddr, ex_mem_o_wdata
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM 2-entry in-order skid buffer; one-cycle latency; ready depends on occupancy only.
// Define EX_MEM_STALL_CNT_EN to add the saturating back-pressure counter output ex_mem_o_stall_cnt.
module ex_mem (
  input  logic        clk,
  input  logic        rst_,
  ex_mem_if.slave     bus
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0] ex_mem_o_stall_cnt
`endif
);

  typedef struct packed {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q;
  entry_t head_q;
  entry_t tail_q;
  entry_t in_ent;
  logic   accept;
  logic   deliver;

  assign in_ent  = '{wreg: bus.ex_mem_i_wreg, waddr: bus.ex_mem_i_waddr, wdata: bus.ex_mem_i_wdata};
  assign accept  = bus.ex_mem_i_valid & bus.ex_mem_o_ready;
  assign deliver = bus.ex_mem_o_valid & bus.ex_mem_i_ready;

  // Ready is forced low by the async reset so it drops without waiting for an edge.
  assign bus.ex_mem_o_ready = rst_ & (state_q != FULL);
  assign bus.ex_mem_o_valid = (state_q != EMPTY);
  assign bus.ex_mem_o_wreg  = bus.ex_mem_o_valid ? head_q.wreg  : 1'b0;
  assign bus.ex_mem_o_waddr = bus.ex_mem_o_valid ? head_q.waddr : 5'd0;
  assign bus.ex_mem_o_wdata = bus.ex_mem_o_valid ? head_q.wdata : 32'd0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (bus.ex_mem_i_flush) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= in_ent;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && !deliver) begin
            tail_q  <= in_ent;
            state_q <= FULL;
          end else if (accept && deliver) begin
            head_q  <= in_ent;
          end else if (deliver) begin
            head_q  <= '0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            head_q  <= tail_q;
            tail_q  <= '0;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          head_q  <= '0;
          tail_q  <= '0;
        end
      endcase
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts edges where the head is stuck; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stall_cnt_q <= 16'd0;
    end else if (bus.ex_mem_o_valid && !bus.ex_mem_i_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign ex_mem_o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed scenarios plus random traffic, all compared against a queue model.
module tb_ex_mem;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  ex_mem_if ifc ();

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
  ex_mem dut (.clk(clk), .rst_(rst_), .bus(ifc), .ex_mem_o_stall_cnt(stall_cnt));
`else
  ex_mem dut (.clk(clk), .rst_(rst_), .bus(ifc));
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] q[$];
  int exp_stall = 0;

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] out_ent();
    return {ifc.ex_mem_o_wreg, ifc.ex_mem_o_waddr, ifc.ex_mem_o_wdata};
  endfunction

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    ifc.ex_mem_i_valid = v;
    ifc.ex_mem_i_wreg  = w;
    ifc.ex_mem_i_waddr = a;
    ifc.ex_mem_i_wdata = d;
  endtask

  // Checks the current outputs against the model, then advances one edge with the inputs now applied.
  task automatic cycle();
    bit acc, del, fl;
    logic [37:0] exp_head;
    exp_head = (q.size() > 0) ? q[0] : 38'd0;
    chk("o_ready", {37'd0, ifc.ex_mem_o_ready}, {37'd0, q.size() < 2});
    chk("o_valid", {37'd0, ifc.ex_mem_o_valid}, {37'd0, q.size() > 0});
    chk("o_head", out_ent(), exp_head);
`ifdef EX_MEM_STALL_CNT_EN
    chk("stall_cnt", {22'd0, stall_cnt}, 38'(exp_stall));
`endif
    acc = ifc.ex_mem_i_valid && (q.size() < 2);
    del = (q.size() > 0) && ifc.ex_mem_i_ready;
    fl  = ifc.ex_mem_i_flush;
    if ((q.size() > 0) && !ifc.ex_mem_i_ready && exp_stall < 65535) exp_stall++;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back({ifc.ex_mem_i_wreg, ifc.ex_mem_i_waddr, ifc.ex_mem_i_wdata});
    end
  endtask

  task automatic do_reset();
    #3;
    rst_ = 1'b0;
    q.delete();
    exp_stall = 0;
    #1;
    chk("rst_valid", {37'd0, ifc.ex_mem_o_valid}, 38'd0);
    chk("rst_ready", {37'd0, ifc.ex_mem_o_ready}, 38'd0);
    chk("rst_data", out_ent(), 38'd0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("rst_stall", {22'd0, stall_cnt}, 38'd0);
`endif
    #1;
    rst_ = 1'b1;
    #1;
    chk("post_rst_ready", {37'd0, ifc.ex_mem_o_ready}, 38'd1);
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    ifc.ex_mem_i_flush = 1'b0;
    ifc.ex_mem_i_ready = 1'b0;
    #12;
    chk("rst_valid0", {37'd0, ifc.ex_mem_o_valid}, 38'd0);
    chk("rst_ready0", {37'd0, ifc.ex_mem_o_ready}, 38'd0);
    chk("rst_data0", out_ent(), 38'd0);
    rst_ = 1'b1;
    #1;
    chk("post_rst_ready0", {37'd0, ifc.ex_mem_o_ready}, 38'd1);
    @(posedge clk);
    #1;

    // Single accept with consumer ready.
    ifc.ex_mem_i_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 32'h0000_00FF);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    chk("single_valid", {37'd0, ifc.ex_mem_o_valid}, 38'd1);
    chk("single_data", out_ent(), {1'b1, 5'd3, 32'h0000_00FF});
    cycle();
    chk("single_empty", {37'd0, ifc.ex_mem_o_valid}, 38'd0);

    // Fill to FULL, third input refused, drain in order.
    ifc.ex_mem_i_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 32'h11);
    cycle();
    drive(1'b1, 1'b1, 5'd2, 32'h22);
    cycle();
    chk("full_ready", {37'd0, ifc.ex_mem_o_ready}, 38'd0);
    drive(1'b1, 1'b1, 5'd4, 32'h33);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    ifc.ex_mem_i_ready = 1'b1;
    chk("drain_first", out_ent(), {1'b1, 5'd1, 32'h11});
    cycle();
    chk("drain_second", out_ent(), {1'b1, 5'd2, 32'h22});
    cycle();
    chk("drain_empty", {37'd0, ifc.ex_mem_o_valid}, 38'd0);

    // Accept and deliver together in ONE, with a wreg=0 entry.
    ifc.ex_mem_i_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 32'h11);
    cycle();
    ifc.ex_mem_i_ready = 1'b1;
    drive(1'b1, 1'b0, 5'd9, 32'h44);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    chk("pass_valid", {37'd0, ifc.ex_mem_o_valid}, 38'd1);
    chk("pass_ready", {37'd0, ifc.ex_mem_o_ready}, 38'd1);
    chk("pass_head", out_ent(), {1'b0, 5'd9, 32'h44});
    cycle();

    // Flush while FULL, with a simultaneous input that must vanish.
    ifc.ex_mem_i_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd6, 32'h66);
    cycle();
    drive(1'b1, 1'b1, 5'd7, 32'h77);
    cycle();
    drive(1'b1, 1'b1, 5'd5, 32'h55);
    ifc.ex_mem_i_flush = 1'b1;
    cycle();
    ifc.ex_mem_i_flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    chk("flush_valid", {37'd0, ifc.ex_mem_o_valid}, 38'd0);
    chk("flush_data", out_ent(), 38'd0);
    ifc.ex_mem_i_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset while FULL.
    ifc.ex_mem_i_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 32'h88);
    cycle();
    drive(1'b1, 1'b1, 5'd9, 32'h99);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    do_reset();
    cycle();

`ifdef EX_MEM_STALL_CNT_EN
    ifc.ex_mem_i_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 32'hAA);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    chk("stall_ten", {22'd0, stall_cnt}, 38'd10);
    for (int i = 0; i < 65530; i++) cycle();
    chk("stall_sat", {22'd0, stall_cnt}, 38'hFFFF);
    ifc.ex_mem_i_flush = 1'b1;
    cycle();
    ifc.ex_mem_i_flush = 1'b0;
    chk("stall_flush_keep", {22'd0, stall_cnt}, 38'hFFFF);
    do_reset();
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom), 5'($urandom), $urandom);
      ifc.ex_mem_i_ready = ($urandom_range(0, 3) != 0);
      ifc.ex_mem_i_flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    ifc.ex_mem_i_flush = 1'b0;
    ifc.ex_mem_i_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL have the port `clk  input  1  sole clock`; all state SHALL update on its rising edge.
REQ-002 The block SHALL have the port `rst_  input  1  reset, asynchronous, active-low`.
REQ-003 The block SHALL have the port `ex_mem_i_valid  input  1  execute-stage result present this cycle`.
REQ-004 The block SHALL have the port `ex_mem_o_ready  output  1  buffer can accept an entry this cycle`.
REQ-005 The block SHALL have the ports `ex_mem_i_wreg  input  1`, `ex_mem_i_waddr  input  5` and `ex_mem_i_wdata  input  32`, carrying the execute-stage write-back request.
REQ-006 The block SHALL have the port `ex_mem_i_flush  input  1  discard all buffered entries`.
REQ-007 The block SHALL have the port `ex_mem_o_valid  output  1  head entry presented to the memory stage`.
REQ-008 The block SHALL have the port `ex_mem_i_ready  input  1  memory stage accepts the head entry`.
REQ-009 The block SHALL have the ports `ex_mem_o_wreg  output  1`, `ex_mem_o_waddr  output  5` and `ex_mem_o_wdata  output  32`, carrying the head entry.
REQ-010 The block SHALL have the port `ex_mem_o_stall_cnt  output  16  back-pressure cycle count`, present only per REQ-027.

Function
REQ-011 The block SHALL be a 2-entry in-order buffer holding {wreg, waddr, wdata} with states EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-012 An accept SHALL occur when ex_mem_i_valid=1 and ex_mem_o_ready=1; a deliver SHALL occur when ex_mem_o_valid=1 and ex_mem_i_ready=1.
REQ-013 ex_mem_o_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL depend on state only, never combinationally on ex_mem_i_ready.
REQ-014 ex_mem_o_valid SHALL be 1 exactly in ONE and FULL.
REQ-015 Latency SHALL be one cycle: an entry accepted at edge N SHALL appear on the outputs after edge N when the buffer was EMPTY.
REQ-016 State transitions SHALL be: EMPTY+accept -> ONE; ONE+accept without deliver -> FULL; ONE+deliver without accept -> EMPTY; ONE+accept+deliver -> ONE with the new entry at head; FULL+deliver -> ONE with the second entry promoted to head; all other cases hold state.
REQ-017 Entries SHALL leave in accept order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-018 Entries with wreg=0 SHALL be buffered and delivered like any other entry.
REQ-019 While ex_mem_o_valid=0, ex_mem_o_wreg, ex_mem_o_waddr and ex_mem_o_wdata SHALL be driven to 0.
REQ-020 ex_mem_i_flush=1 at an edge SHALL set the state to EMPTY, overriding any accept or deliver at that edge; input data presented that cycle SHALL be discarded.
REQ-021 A deliver and a flush at the same edge SHALL count as delivered to the consumer; the buffer SHALL NOT re-present that entry.

Reset
REQ-022 While rst_=0, the state SHALL be EMPTY, independent of clk.
REQ-023 While rst_=0, ex_mem_o_valid, ex_mem_o_ready, ex_mem_o_wreg, ex_mem_o_waddr and ex_mem_o_wdata SHALL all be 0, and ex_mem_o_stall_cnt SHALL be 0 when present.
REQ-024 After rst_ deasserts, ex_mem_o_ready SHALL be 1 and the first edge SHALL accept normally.
REQ-025 rst_ asserted mid-operation SHALL discard all entries immediately.

Configuration
REQ-026 The macro EX_MEM_STALL_CNT_EN SHALL control the stall counter.
REQ-027 With EX_MEM_STALL_CNT_EN defined, ex_mem_o_stall_cnt SHALL exist and SHALL increment by 1 each edge where ex_mem_o_valid=1 and ex_mem_i_ready=0.
REQ-028 With EX_MEM_STALL_CNT_EN defined, ex_mem_o_stall_cnt SHALL saturate at 16'hFFFF, SHALL be unaffected by flush, and SHALL be cleared only by reset.
REQ-029 Without EX_MEM_STALL_CNT_EN, the port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: reset, then one accept of {1,5'd3,32'h0000_00FF} with i_ready=1 -> outputs {valid=1,1,3,0xFF} after next edge, EMPTY one edge later.
REQ-031 The bench SHALL cover: i_ready=0, accept A=0x11 then B=0x22 -> o_ready=0 (FULL); a third input 0x33 is not accepted; i_ready=1 -> delivers 0x11 then 0x22 in order.
REQ-032 The bench SHALL cover: ONE with head 0x11, simultaneous accept 0x44 and deliver -> state stays ONE, head=0x44.
REQ-033 The bench SHALL cover: FULL, flush=1 together with i_valid=1 (0x55) -> EMPTY, o_valid=0, all outputs 0, 0x55 never delivered.
REQ-034 The bench SHALL cover: rst_ pulled low between clock edges while FULL -> outputs 0 immediately, without waiting for a clock edge.
REQ-035 The bench SHALL cover, with EX_MEM_STALL_CNT_EN: valid held with i_ready=0 for 10 cycles -> stall_cnt=10; preset near 0xFFFF -> stall_cnt holds at 0xFFFF.
